// File: rtl/trace_stream_arbiter.sv
// Round-robin merge of NUM_SRC AXI-Stream trace sources into one tagged stream.
// A grant is held until TLAST or MAX_BURST beats; one registered output stage.
module trace_stream_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                   AXI_ACLK,
    input  logic                   AXI_ARESETN,
    input  logic                   enable,
    input  logic [NUM_SRC-1:0]     S_AXIS_TVALID,
    output logic [NUM_SRC-1:0]     S_AXIS_TREADY,
    input  logic [32*NUM_SRC-1:0]  S_AXIS_TDATA,
    input  logic [NUM_SRC-1:0]     S_AXIS_TLAST,
    output logic                   M_AXIS_TVALID,
    input  logic                   M_AXIS_TREADY,
    output logic [31:0]            M_AXIS_TDATA,
    output logic                   M_AXIS_TLAST,
    output logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] M_AXIS_TID,
    output logic                   busy
);

    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [SRC_W-1:0]   ptr_q;
    logic [SRC_W-1:0]   gnt_q;
    logic [SRC_W-1:0]   pick;
    logic [SRC_W-1:0]   idx;
    logic [SRC_W-1:0]   gnt_next;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        sel_data;
    logic               sel_last;
    logic               out_free;
    logic               accept;
    logic               cut;
    logic               release_g;
    logic               start_g;

    // Scan downward so the lowest offset from ptr is the one that sticks.
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = SRC_W'((int'(ptr_q) + k) % NUM_SRC);
            if (S_AXIS_TVALID[idx]) pick = idx;
        end
    end

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt_q == SRC_W'(i)) begin
                sel_data = S_AXIS_TDATA[32*i +: 32];
                sel_last = S_AXIS_TLAST[i];
            end
        end
    end

    assign out_free = !M_AXIS_TVALID || M_AXIS_TREADY;
    assign cut      = (cnt_q == CNT_W'(MAX_BURST - 1));
    assign gnt_next = (gnt_q == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_q + 1'b1;
    assign busy     = (state_q == GRANT);

    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_ARESETN) state_q <= IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        S_AXIS_TREADY = '0;
        accept        = 1'b0;
        release_g     = 1'b0;
        start_g       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable && |S_AXIS_TVALID) begin
                    start_g = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                S_AXIS_TREADY[gnt_q] = out_free;
                accept    = S_AXIS_TVALID[gnt_q] && out_free;
                release_g = accept && (sel_last || cut);
                if (release_g) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_ARESETN) begin
            ptr_q         <= '0;
            gnt_q         <= '0;
            cnt_q         <= '0;
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TLAST  <= 1'b0;
            M_AXIS_TID    <= '0;
        end else begin
            if (start_g) begin
                gnt_q <= pick;
                cnt_q <= '0;
            end
            if (accept) begin
                cnt_q        <= cnt_q + CNT_W'(1);
                M_AXIS_TDATA <= sel_data;
                M_AXIS_TLAST <= sel_last || cut;
                M_AXIS_TID   <= gnt_q;
            end
            if (release_g) ptr_q <= gnt_next;
            // A load in the same cycle as a drain keeps the stage full.
            if (accept)             M_AXIS_TVALID <= 1'b1;
            else if (M_AXIS_TREADY) M_AXIS_TVALID <= 1'b0;
        end
    end

endmodule
